// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects ecall, mret and timer interrupts, drives the
// CSR-file trap write port and redirects the PC while holding the pipeline.
module trap_ctrl #(
  parameter logic [63:0] CAUSE_ECALL = 64'd11,
  parameter logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        inst_ecall_i,
  input  logic        inst_mret_i,
  input  logic [63:0] inst_pc_i,
  input  logic [63:0] next_pc_i,
  input  logic        timer_irq_i,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  input  logic [63:0] mcause_i,
  output logic        clint_csr_wen_o,
  output logic [63:0] mstatus_o,
  output logic [63:0] mepc_o,
  output logic [63:0] mcause_o,
  output logic        hold_o,
  output logic        jump_o,
  output logic [63:0] jump_addr_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    JUMP    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [63:0] epc_r;
  logic [63:0] cause_r;
  logic [63:0] target_r;
  logic        take_ecall_s;
  logic        take_mret_s;
  logic        take_irq_s;
  logic [63:0] vec_base_s;
  logic [63:0] trap_vec_s;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [63:0] mstatus_trap(input logic [63:0] ms);
    logic [63:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1, MPP stays M (only M-mode exists).
  function automatic logic [63:0] mstatus_ret(input logic [63:0] ms);
    logic [63:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap request decode with priority ecall > mret > timer interrupt.
  always_comb begin
    take_ecall_s = inst_valid_i & inst_ecall_i;
    take_mret_s  = inst_valid_i & ~inst_ecall_i & inst_mret_i;
    take_irq_s   = inst_valid_i & ~inst_ecall_i & ~inst_mret_i & timer_irq_i & mstatus_i[3];
  end

  // Trap vector; vectored mode offsets interrupts by 4*cause, wrapping at 64 bits.
  always_comb begin
    vec_base_s = {mtvec_i[63:2], 2'b00};
    if ((mtvec_i[1:0] == 2'b01) && cause_r[63]) begin
      trap_vec_s = vec_base_s + ({1'b0, cause_r[62:0]} << 3'd2);
    end else begin
      trap_vec_s = vec_base_s;
    end
  end

  // State register plus latched return point, cause and redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      epc_r    <= 64'd0;
      cause_r  <= 64'd0;
      target_r <= 64'd0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (take_ecall_s) begin
            epc_r   <= inst_pc_i;
            cause_r <= CAUSE_ECALL;
          end else if (take_irq_s) begin
            epc_r   <= next_pc_i;
            cause_r <= CAUSE_MTI;
          end
        end
        SAVE:    target_r <= trap_vec_s;
        RESTORE: target_r <= mepc_i;
        default: target_r <= target_r;
      endcase
    end
  end

  // Next-state and output decode; every output is zero unless its state drives it.
  always_comb begin
    state_next_s    = state_r;
    clint_csr_wen_o = 1'b0;
    mstatus_o       = 64'd0;
    mepc_o          = 64'd0;
    mcause_o        = 64'd0;
    hold_o          = 1'b0;
    jump_o          = 1'b0;
    jump_addr_o     = 64'd0;
    busy_o          = 1'b0;
    case (state_r)
      IDLE: begin
        // Gated by rst so the detect-cycle hold cannot leak out during reset.
        hold_o = rst & (take_ecall_s | take_mret_s | take_irq_s);
        if (take_ecall_s | take_irq_s) begin
          state_next_s = SAVE;
        end else if (take_mret_s) begin
          state_next_s = RESTORE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SAVE: begin
        clint_csr_wen_o = 1'b1;
        mstatus_o       = mstatus_trap(mstatus_i);
        mepc_o          = epc_r;
        mcause_o        = cause_r;
        hold_o          = 1'b1;
        busy_o          = 1'b1;
        state_next_s    = JUMP;
      end
      RESTORE: begin
        clint_csr_wen_o = 1'b1;
        mstatus_o       = mstatus_ret(mstatus_i);
        mepc_o          = mepc_i;
        mcause_o        = mcause_i;
        hold_o          = 1'b1;
        busy_o          = 1'b1;
        state_next_s    = JUMP;
      end
      JUMP: begin
        jump_o       = 1'b1;
        jump_addr_o  = target_r;
        hold_o       = 1'b1;
        busy_o       = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: stimulus pushes expected CSR writes and redirects
// into a scoreboard; a negedge monitor pops and compares whenever the DUT emits one.
module tb_trap_ctrl;

  localparam logic [63:0] MTI = 64'h8000_0000_0000_0007;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, inst_ecall_i, inst_mret_i, timer_irq_i;
  logic [63:0] inst_pc_i, next_pc_i, mstatus_i, mtvec_i, mepc_i, mcause_i;
  logic        clint_csr_wen_o, hold_o, jump_o, busy_o;
  logic [63:0] mstatus_o, mepc_o, mcause_o, jump_addr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_jump;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } exp_t;

  exp_t sb[$];

  trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .inst_valid_i    (inst_valid_i),
    .inst_ecall_i    (inst_ecall_i),
    .inst_mret_i     (inst_mret_i),
    .inst_pc_i       (inst_pc_i),
    .next_pc_i       (next_pc_i),
    .timer_irq_i     (timer_irq_i),
    .mstatus_i       (mstatus_i),
    .mtvec_i         (mtvec_i),
    .mepc_i          (mepc_i),
    .mcause_i        (mcause_i),
    .clint_csr_wen_o (clint_csr_wen_o),
    .mstatus_o       (mstatus_o),
    .mepc_o          (mepc_o),
    .mcause_o        (mcause_o),
    .hold_o          (hold_o),
    .jump_o          (jump_o),
    .jump_addr_o     (jump_addr_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic all_zero(input string name);
    chk({name, "_wen"}, {63'd0, clint_csr_wen_o}, 64'd0);
    chk({name, "_mstatus"}, mstatus_o, 64'd0);
    chk({name, "_mepc"}, mepc_o, 64'd0);
    chk({name, "_mcause"}, mcause_o, 64'd0);
    chk({name, "_hold"}, {63'd0, hold_o}, 64'd0);
    chk({name, "_jump"}, {63'd0, jump_o}, 64'd0);
    chk({name, "_jaddr"}, jump_addr_o, 64'd0);
    chk({name, "_busy"}, {63'd0, busy_o}, 64'd0);
  endtask

  task automatic clear_inputs();
    inst_valid_i = 1'b0;
    inst_ecall_i = 1'b0;
    inst_mret_i  = 1'b0;
    timer_irq_i  = 1'b0;
  endtask

  // Called at posedge+1 in IDLE with no trap request: expect no hold, not busy.
  task automatic idle_check(input string name);
    @(negedge clk);
    chk({name, "_hold"}, {63'd0, hold_o}, 64'd0);
    chk({name, "_busy"}, {63'd0, busy_o}, 64'd0);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 in IDLE with a trap request on the inputs.
  task automatic seq(input string name, input logic [63:0] ms, input logic [63:0] ep,
                     input logic [63:0] mc, input logic [63:0] ja, input bit keep);
    exp_t e;
    e.is_jump = 1'b0; e.a = ms; e.b = ep; e.c = mc;
    sb.push_back(e);
    e.is_jump = 1'b1; e.a = ja; e.b = 64'd0; e.c = 64'd0;
    sb.push_back(e);
    @(negedge clk);
    chk({name, "_det_hold"}, {63'd0, hold_o}, 64'd1);
    chk({name, "_det_busy"}, {63'd0, busy_o}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_wr_hold"}, {63'd0, hold_o}, 64'd1);
    chk({name, "_wr_busy"}, {63'd0, busy_o}, 64'd1);
    @(posedge clk); #1;
    clear_inputs();
    if (keep) begin
      inst_valid_i = 1'b1;
      inst_ecall_i = 1'b1;
      inst_pc_i    = 64'h8000_0020;
    end
    @(negedge clk);
    chk({name, "_jmp_hold"}, {63'd0, hold_o}, 64'd1);
    chk({name, "_jmp_busy"}, {63'd0, busy_o}, 64'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clint_csr_wen_o === 1'b1 || jump_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: wen=%0b jump=%0b with nothing expected",
                   clint_csr_wen_o, jump_o);
        end else begin
          e = sb.pop_front();
          if (!e.is_jump) begin
            chk("sb_wen", {63'd0, clint_csr_wen_o}, 64'd1);
            chk("sb_wr_jump", {63'd0, jump_o}, 64'd0);
            chk("sb_mstatus", mstatus_o, e.a);
            chk("sb_mepc", mepc_o, e.b);
            chk("sb_mcause", mcause_o, e.c);
            chk("sb_wr_jaddr", jump_addr_o, 64'd0);
          end else begin
            chk("sb_jump", {63'd0, jump_o}, 64'd1);
            chk("sb_jmp_wen", {63'd0, clint_csr_wen_o}, 64'd0);
            chk("sb_jaddr", jump_addr_o, e.a);
            chk("sb_jmp_mepc", mepc_o, 64'd0);
            chk("sb_jmp_mcause", mcause_o, 64'd0);
            chk("sb_jmp_mstatus", mstatus_o, 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    inst_pc_i = 64'd0; next_pc_i = 64'd0; mstatus_i = 64'd0;
    mtvec_i = 64'd0; mepc_i = 64'd0; mcause_i = 64'd0;

    // Reset held with a live ecall, then random inputs.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        inst_valid_i = 1'b1; inst_ecall_i = 1'b1; mstatus_i = 64'h8;
      end else begin
        inst_valid_i = 1'($urandom); inst_ecall_i = 1'($urandom);
        inst_mret_i  = 1'($urandom); timer_irq_i  = 1'($urandom);
        inst_pc_i = {$urandom, $urandom}; next_pc_i = {$urandom, $urandom};
        mstatus_i = {$urandom, $urandom}; mtvec_i = {$urandom, $urandom};
        mepc_i = {$urandom, $urandom}; mcause_i = {$urandom, $urandom};
      end
      @(negedge clk);
      all_zero("reset");
    end
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1;

    // ecall
    inst_valid_i = 1'b1; inst_ecall_i = 1'b1; inst_pc_i = 64'h8000_0010;
    mstatus_i = 64'h8; mtvec_i = 64'h8000_0100;
    seq("ecall", 64'h1880, 64'h8000_0010, 64'd11, 64'h8000_0100, 1'b0);
    idle_check("ecall_done");

    // mret
    inst_valid_i = 1'b1; inst_mret_i = 1'b1; mepc_i = 64'h8000_0014;
    mstatus_i = 64'h1880; mcause_i = 64'd11;
    seq("mret", 64'h1888, 64'h8000_0014, 64'd11, 64'h8000_0014, 1'b0);
    idle_check("mret_done");

    // Vectored timer interrupt
    inst_valid_i = 1'b1; timer_irq_i = 1'b1; mstatus_i = 64'h8;
    next_pc_i = 64'h8000_0040; inst_pc_i = 64'h8000_0030; mtvec_i = 64'h8000_0101;
    seq("irq_vec", 64'h1880, 64'h8000_0040, MTI, 64'h8000_011C, 1'b0);

    // Interrupt masked by MIE=0, then irq/ecall with inst_valid_i=0
    inst_valid_i = 1'b1; timer_irq_i = 1'b1; mstatus_i = 64'h0;
    for (int i = 0; i < 3; i++) idle_check("irq_masked");
    inst_valid_i = 1'b0; inst_ecall_i = 1'b1; mstatus_i = 64'h8;
    for (int i = 0; i < 2; i++) idle_check("not_valid");
    clear_inputs();

    // ecall + irq together: ecall wins, irq waits for mret to restore MIE
    inst_valid_i = 1'b1; inst_ecall_i = 1'b1; timer_irq_i = 1'b1; mstatus_i = 64'h8;
    inst_pc_i = 64'h8000_0050; next_pc_i = 64'h8000_0054; mtvec_i = 64'h8000_0101;
    seq("ecall_irq", 64'h1880, 64'h8000_0050, 64'd11, 64'h8000_0100, 1'b0);
    inst_valid_i = 1'b1; timer_irq_i = 1'b1; mstatus_i = 64'h1880;
    for (int i = 0; i < 2; i++) idle_check("irq_wait");
    inst_mret_i = 1'b1; mepc_i = 64'h8000_0054; mcause_i = 64'd11;
    seq("mret_irq", 64'h1888, 64'h8000_0054, 64'd11, 64'h8000_0054, 1'b0);
    inst_valid_i = 1'b1; timer_irq_i = 1'b1; mstatus_i = 64'h1888; next_pc_i = 64'h8000_0058;
    seq("irq_after", 64'h1880, 64'h8000_0058, MTI, 64'h8000_011C, 1'b0);
    idle_check("irq_after_done");

    // ecall asserted during JUMP is ignored, then starts a sequence once in IDLE
    inst_valid_i = 1'b1; inst_mret_i = 1'b1; mepc_i = 64'h8000_0014;
    mstatus_i = 64'h1880; mcause_i = 64'd11; mtvec_i = 64'h8000_0100;
    seq("mret_keep", 64'h1888, 64'h8000_0014, 64'd11, 64'h8000_0014, 1'b1);
    seq("ecall_late", 64'h1800, 64'h8000_0020, 64'd11, 64'h8000_0100, 1'b0);
    idle_check("late_done");

    // Direct-mode interrupt goes to the base
    inst_valid_i = 1'b1; timer_irq_i = 1'b1; mstatus_i = 64'h8;
    next_pc_i = 64'h8000_0060; mtvec_i = 64'h8000_0200;
    seq("irq_direct", 64'h1880, 64'h8000_0060, MTI, 64'h8000_0200, 1'b0);

    // Reset in SAVE aborts the sequence
    inst_valid_i = 1'b1; inst_ecall_i = 1'b1; inst_pc_i = 64'h8000_0070; mstatus_i = 64'h8;
    @(posedge clk); #1;
    chk("save_entered_busy", {63'd0, busy_o}, 64'd1);
    rst = 1'b0;
    #1;
    all_zero("rst_mid_save");
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle_check("post_rst");

    // Normal operation after reset
    inst_valid_i = 1'b1; inst_ecall_i = 1'b1; inst_pc_i = 64'h8000_0080;
    mstatus_i = 64'h8; mtvec_i = 64'h8000_0100;
    seq("ecall_post_rst", 64'h1880, 64'h8000_0080, 64'd11, 64'h8000_0100, 1'b0);
    idle_check("final");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
